sc_mult_sequencer: RTL and testbench
====================================

Name: sc_mult_sequencer

Overview:
- Microsequencer that drives the uDATAPATH control buses. It computes PROD = MCAND × MPLIER by repeated addition and decrement, branching on the datapath's active-low flags.
- Sits beside uDATAPATH inside BB_SYSTEM, in the control slot.
- Start/busy/done handshake toward a host; final product is loaded into the shift register, which drives the output bus.

Parameters:
- DATAWIDTH_DECODER_SELECTION, 4, width of the decoder clear/load selection codes
- DATAWIDTH_MUX_SELECTION, 3, width of the BUS_A/BUS_B mux selects
- DATAWIDTH_ALU_SELECTION, 4, width of the ALU opcode
- DATAWIDTH_REGSHIFTER_SELECTION, 2, width of the shifter mode select
- DEC_PROD, 4'd2, decoder code of the product register
- DEC_MPLIER, 4'd1, decoder code of the multiplier register
- MUX_MCAND, 3'd0, mux code of the multiplicand register
- MUX_MPLIER, 3'd1, mux code of the multiplier register
- MUX_PROD, 3'd2, mux code of the product register
- MAX_ITER, 8'd255, iteration limit before the error abort

Ports:
- SC_MULTSEQ_CLOCK_50  in  1  system clock
- SC_MULTSEQ_RESET_InLow  in  1  synchronous reset, active low
- SC_MULTSEQ_start_InHigh  in  1  start request, sampled in IDLE only
- SC_MULTSEQ_overflow_InLow  in  1  ALU overflow flag, 0 = overflow
- SC_MULTSEQ_carry_InLow  in  1  ALU carry flag (unused, reserved)
- SC_MULTSEQ_negative_InLow  in  1  ALU negative flag (unused, reserved)
- SC_MULTSEQ_zero_InLow  in  1  ALU zero flag, 0 = result zero
- SC_MULTSEQ_decoderclearselection_OutBUS  out  4  register to clear
- SC_MULTSEQ_decoderloadselection_OutBUS  out  4  register to load from BUS_C
- SC_MULTSEQ_muxselectionBUSA_OutBUS  out  3  BUS_A source
- SC_MULTSEQ_muxselectionBUSB_OutBUS  out  3  BUS_B source
- SC_MULTSEQ_aluselection_OutBUS  out  4  ALU opcode
- SC_MULTSEQ_regSHIFTERclear_OutLow  out  1  shifter clear, active low
- SC_MULTSEQ_regSHIFTERload_OutLow  out  1  shifter load, active low
- SC_MULTSEQ_regSHIFTERshiftselection_OutLow  out  2  shifter mode
- SC_MULTSEQ_busy_OutHigh  out  1  operation in progress
- SC_MULTSEQ_done_OutHigh  out  1  one-cycle completion pulse
- SC_MULTSEQ_error_OutHigh  out  1  overflow or iteration-limit abort

Behaviour:
- Single clock domain; every state and output register updates on the rising edge.
- Reset is synchronous, active low (SC_MULTSEQ_RESET_InLow = 0 at an edge). It applies mid-operation too.
  - Next state is IDLE; iteration counter is 0; busy, done and error are 0.
  - Both decoder selects are DEC_NONE (4'b1111, selects no register); both mux selects are 0; ALU opcode is ALU_PASSA.
  - Shifter clear and load are 1 (inactive); shift select is SHIFT_HOLD (2'b00).
  - Datapath register contents are not restored.
- Control outputs are Moore, decoded from the state. Any field not listed below holds its idle value.
- States and transitions:
  - IDLE: busy=0. On start=1, go to CLR; counter is cleared to 0 and error is cleared to 0.
  - CLR: decoderclear=DEC_PROD; shifter clear=0. Go to TEST.
  - TEST: BUS_A=MUX_MPLIER, ALU_PASSA.
    - zero_InLow=0 → LOADOUT.
    - Else, if counter==MAX_ITER → error=1, LOADOUT.
    - Else → ADD.
  - ADD: BUS_A=MUX_PROD, BUS_B=MUX_MCAND, ALU_ADD, decoderload=DEC_PROD.
    - overflow_InLow=0 → error=1, LOADOUT. The product register keeps the wrapped sum loaded at that edge.
    - Else → DEC.
  - DEC: BUS_A=MUX_MPLIER, ALU_DECA, decoderload=DEC_MPLIER. Counter +1. Go to TEST.
  - LOADOUT: BUS_A=MUX_PROD, ALU_PASSA, shifter load=0. Go to DONE.
  - DONE: done=1 for exactly one cycle. Go to IDLE.
- busy=1 in every state except IDLE.
- Flags are combinational from the ALU and sampled at the edge that ends the state driving that ALU operation.
- start during busy is ignored; there is no queueing.
- Latency: with start sampled at edge k, done is high in the cycle after edge k+3+3·MPLIER. MPLIER=0 → 4 cycles.
- error stays set until the next accepted start.
- MPLIER is destroyed (decremented to 0); MCAND is preserved.

Decomposition:
- Shared package sc_mult_pkg holds:
  - state enum: IDLE, CLR, TEST, ADD, DEC, LOADOUT, DONE (3-bit binary)
  - ALU codes: ALU_PASSA=4'd0, ALU_ADD=4'd1, ALU_DECA=4'd2
  - DEC_NONE=4'b1111
  - SHIFT_HOLD=2'b00
- One natural sub-module: sc_mult_itercount, an 8-bit counter with clear, increment and a limit compare.

Test Plan:
- MCAND=9, MPLIER=3, start pulse → busy for 12 cycles, done in cycle 13; shifter loaded with 27; error=0.
- MPLIER=0 → only CLR, TEST, LOADOUT, DONE; product 0; done 4 cycles after start.
- MCAND=0x7FFFFFFF, MPLIER=2, overflow forced low on the 2nd ADD → error=1, jump to LOADOUT, done pulse follows.
- MAX_ITER=2, MPLIER=5 → third TEST aborts with error=1; product 2·MCAND.
- Reset low mid-ADD → next edge IDLE, all outputs at reset values; a new start runs a clean sequence.
- start held high through busy and done → second operation begins only after return to IDLE; done pulses never merge.

Source files
------------

// File: rtl/sc_mult_pkg.sv
// Shared definitions for the multiply microsequencer: state encoding,
// datapath select codes and the packed control word driven onto the buses.
package sc_mult_pkg;

    localparam int DATAWIDTH_DECODER_SELECTION    = 4;
    localparam int DATAWIDTH_MUX_SELECTION        = 3;
    localparam int DATAWIDTH_ALU_SELECTION        = 4;
    localparam int DATAWIDTH_REGSHIFTER_SELECTION = 2;

    // Decoder codes (clear/load targets); all ones selects no register
    localparam logic [3:0] DEC_MPLIER = 4'd1;
    localparam logic [3:0] DEC_PROD   = 4'd2;
    localparam logic [3:0] DEC_NONE   = 4'b1111;

    // BUS_A / BUS_B mux sources
    localparam logic [2:0] MUX_MCAND  = 3'd0;
    localparam logic [2:0] MUX_MPLIER = 3'd1;
    localparam logic [2:0] MUX_PROD   = 3'd2;

    // ALU opcodes used by the sequence
    localparam logic [3:0] ALU_PASSA = 4'd0;
    localparam logic [3:0] ALU_ADD   = 4'd1;
    localparam logic [3:0] ALU_DECA  = 4'd2;

    localparam logic [1:0] SHIFT_HOLD = 2'b00;

    localparam logic [7:0] MAX_ITER_DEFAULT = 8'd255;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLR     = 3'd1,
        TEST    = 3'd2,
        ADD     = 3'd3,
        DEC     = 3'd4,
        LOADOUT = 3'd5,
        DONE    = 3'd6
    } seqState_t;

    // Everything the sequencer drives toward the datapath and the host
    typedef struct packed {
        logic [3:0] decClr;
        logic [3:0] decLoad;
        logic [2:0] muxA;
        logic [2:0] muxB;
        logic [3:0] alu;
        logic       shClrLow;
        logic       shLoadLow;
        logic [1:0] shSel;
        logic       busy;
        logic       done;
    } ctrlWord_t;

    // Control word of an idle sequencer: nothing selected, shifter inactive
    function automatic ctrlWord_t idleCtrl();
        ctrlWord_t c;
        c.decClr    = DEC_NONE;
        c.decLoad   = DEC_NONE;
        c.muxA      = 3'd0;
        c.muxB      = 3'd0;
        c.alu       = ALU_PASSA;
        c.shClrLow  = 1'b1;
        c.shLoadLow = 1'b1;
        c.shSel     = SHIFT_HOLD;
        c.busy      = 1'b0;
        c.done      = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/sc_mult_itercount.sv
// Iteration counter for the multiply loop: cleared when an operation is
// accepted, bumped once per add/decrement pass, and compared to the limit.
module sc_mult_itercount
    import sc_mult_pkg::*;
#(
    parameter logic [7:0] MAX_ITER = MAX_ITER_DEFAULT
) (
    input  logic clock,
    input  logic resetLow,
    input  logic clear,
    input  logic increment,
    output logic atLimit
);

    logic [7:0] count_r;

    // Count register; saturates at all ones so it can never wrap back below the limit
    always_ff @(posedge clock) begin
        if (!resetLow) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else if (increment && (count_r != 8'hFF)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign atLimit = (count_r == MAX_ITER);

endmodule

// File: rtl/sc_mult_sequencer.sv
// Microsequencer computing PROD = MCAND * MPLIER on the datapath by repeated
// addition and decrement. Control buses are Moore outputs held in registers
// that are loaded from the decode of the next state, so they line up with the
// state they belong to.
module sc_mult_sequencer
    import sc_mult_pkg::*;
#(
    parameter logic [7:0] MAX_ITER = MAX_ITER_DEFAULT
) (
    input  logic SC_MULTSEQ_CLOCK_50,
    input  logic SC_MULTSEQ_RESET_InLow,
    input  logic SC_MULTSEQ_start_InHigh,
    input  logic SC_MULTSEQ_overflow_InLow,
    input  logic SC_MULTSEQ_carry_InLow,
    input  logic SC_MULTSEQ_negative_InLow,
    input  logic SC_MULTSEQ_zero_InLow,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_MULTSEQ_decoderclearselection_OutBUS,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_MULTSEQ_decoderloadselection_OutBUS,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_MULTSEQ_muxselectionBUSA_OutBUS,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_MULTSEQ_muxselectionBUSB_OutBUS,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_MULTSEQ_aluselection_OutBUS,
    output logic SC_MULTSEQ_regSHIFTERclear_OutLow,
    output logic SC_MULTSEQ_regSHIFTERload_OutLow,
    output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_MULTSEQ_regSHIFTERshiftselection_OutLow,
    output logic SC_MULTSEQ_busy_OutHigh,
    output logic SC_MULTSEQ_done_OutHigh,
    output logic SC_MULTSEQ_error_OutHigh
);

    seqState_t state_r;
    seqState_t stateNext_s;
    ctrlWord_t ctrl_r;
    ctrlWord_t ctrlNext_s;
    logic      error_r;
    logic      accept_s;
    logic      iterInc_s;
    logic      errorSet_s;
    logic      atLimit_s;
    logic      unusedFlags_s;

    // Carry and negative are reserved for future microprograms
    assign unusedFlags_s = SC_MULTSEQ_carry_InLow & SC_MULTSEQ_negative_InLow;

    sc_mult_itercount #(
        .MAX_ITER (MAX_ITER)
    ) uIterCount (
        .clock     (SC_MULTSEQ_CLOCK_50),
        .resetLow  (SC_MULTSEQ_RESET_InLow),
        .clear     (accept_s),
        .increment (iterInc_s),
        .atLimit   (atLimit_s)
    );

    // State register
    always_ff @(posedge SC_MULTSEQ_CLOCK_50) begin
        if (!SC_MULTSEQ_RESET_InLow) begin
            state_r <= IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Next-state logic; flags are valid in the state that drives the ALU op they describe
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE: begin
                if (SC_MULTSEQ_start_InHigh) begin
                    stateNext_s = CLR;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            CLR:  stateNext_s = TEST;
            TEST: begin
                if (!SC_MULTSEQ_zero_InLow) begin
                    stateNext_s = LOADOUT;
                end else if (atLimit_s) begin
                    stateNext_s = LOADOUT;
                end else begin
                    stateNext_s = ADD;
                end
            end
            ADD: begin
                if (!SC_MULTSEQ_overflow_InLow) begin
                    stateNext_s = LOADOUT;
                end else begin
                    stateNext_s = DEC;
                end
            end
            DEC:     stateNext_s = TEST;
            LOADOUT: stateNext_s = DONE;
            DONE:    stateNext_s = IDLE;
            default: stateNext_s = IDLE;
        endcase
    end

    // Counter and error qualifiers derived from the current state and flags
    always_comb begin
        accept_s   = (state_r == IDLE) && SC_MULTSEQ_start_InHigh;
        iterInc_s  = (state_r == DEC);
        errorSet_s = ((state_r == TEST) && SC_MULTSEQ_zero_InLow && atLimit_s) ||
                     ((state_r == ADD) && !SC_MULTSEQ_overflow_InLow);
    end

    // Output decode of the state being entered, so the registered buses match it
    always_comb begin
        ctrlNext_s = idleCtrl();
        case (stateNext_s)
            IDLE: begin
                ctrlNext_s = idleCtrl();
            end
            CLR: begin
                ctrlNext_s.decClr   = DEC_PROD;
                ctrlNext_s.shClrLow = 1'b0;
                ctrlNext_s.busy     = 1'b1;
            end
            TEST: begin
                ctrlNext_s.muxA = MUX_MPLIER;
                ctrlNext_s.alu  = ALU_PASSA;
                ctrlNext_s.busy = 1'b1;
            end
            ADD: begin
                ctrlNext_s.muxA    = MUX_PROD;
                ctrlNext_s.muxB    = MUX_MCAND;
                ctrlNext_s.alu     = ALU_ADD;
                ctrlNext_s.decLoad = DEC_PROD;
                ctrlNext_s.busy    = 1'b1;
            end
            DEC: begin
                ctrlNext_s.muxA    = MUX_MPLIER;
                ctrlNext_s.alu     = ALU_DECA;
                ctrlNext_s.decLoad = DEC_MPLIER;
                ctrlNext_s.busy    = 1'b1;
            end
            LOADOUT: begin
                ctrlNext_s.muxA      = MUX_PROD;
                ctrlNext_s.alu       = ALU_PASSA;
                ctrlNext_s.shLoadLow = 1'b0;
                ctrlNext_s.busy      = 1'b1;
            end
            DONE: begin
                ctrlNext_s.busy = 1'b1;
                ctrlNext_s.done = 1'b1;
            end
            default: begin
                ctrlNext_s = idleCtrl();
            end
        endcase
    end

    // Output register for the control word
    always_ff @(posedge SC_MULTSEQ_CLOCK_50) begin
        if (!SC_MULTSEQ_RESET_InLow) begin
            ctrl_r <= idleCtrl();
        end else begin
            ctrl_r <= ctrlNext_s;
        end
    end

    // Sticky error: set on overflow or iteration limit, cleared by the next accepted start
    always_ff @(posedge SC_MULTSEQ_CLOCK_50) begin
        if (!SC_MULTSEQ_RESET_InLow) begin
            error_r <= 1'b0;
        end else if (accept_s) begin
            error_r <= 1'b0;
        end else if (errorSet_s) begin
            error_r <= 1'b1;
        end else begin
            error_r <= error_r;
        end
    end

    assign SC_MULTSEQ_decoderclearselection_OutBUS    = ctrl_r.decClr;
    assign SC_MULTSEQ_decoderloadselection_OutBUS     = ctrl_r.decLoad;
    assign SC_MULTSEQ_muxselectionBUSA_OutBUS         = ctrl_r.muxA;
    assign SC_MULTSEQ_muxselectionBUSB_OutBUS         = ctrl_r.muxB;
    assign SC_MULTSEQ_aluselection_OutBUS             = ctrl_r.alu;
    assign SC_MULTSEQ_regSHIFTERclear_OutLow          = ctrl_r.shClrLow;
    assign SC_MULTSEQ_regSHIFTERload_OutLow           = ctrl_r.shLoadLow;
    assign SC_MULTSEQ_regSHIFTERshiftselection_OutLow = ctrl_r.shSel;
    assign SC_MULTSEQ_busy_OutHigh                    = ctrl_r.busy;
    assign SC_MULTSEQ_done_OutHigh                    = ctrl_r.done;
    assign SC_MULTSEQ_error_OutHigh                   = error_r;

endmodule

// File: tb/tb_sc_mult_sequencer.sv
// Directed bench for sc_mult_sequencer. A small behavioural datapath
// (MCAND/MPLIER/PROD registers, ALU, output shifter) responds to the control
// buses and feeds back the zero/overflow flags.
module tb_sc_mult_sequencer;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic        ovfN;
    logic        zeroN;
    logic [3:0]  decClr;
    logic [3:0]  decLd;
    logic [2:0]  muxA;
    logic [2:0]  muxB;
    logic [3:0]  alu;
    logic        shClrN;
    logic        shLdN;
    logic [1:0]  shSel;
    logic        busy;
    logic        done;
    logic        err;

    // datapath model
    logic [31:0] mcandM  = 32'd0;
    logic [31:0] mplierM = 32'd0;
    logic [31:0] prodM   = 32'd0;
    logic [31:0] shiftM  = 32'd0;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [31:0] aluRes;
    logic        loadReq = 1'b0;
    logic [31:0] loadMcand = 32'd0;
    logic [31:0] loadMplier = 32'd0;
    int          addCount = 0;

    int checks = 0;
    int errors = 0;
    int lat;
    int gap;

    always #5 clk = ~clk;

    sc_mult_sequencer dut (
        .SC_MULTSEQ_CLOCK_50                        (clk),
        .SC_MULTSEQ_RESET_InLow                     (rstN),
        .SC_MULTSEQ_start_InHigh                    (start),
        .SC_MULTSEQ_overflow_InLow                  (ovfN),
        .SC_MULTSEQ_carry_InLow                     (1'b1),
        .SC_MULTSEQ_negative_InLow                  (1'b1),
        .SC_MULTSEQ_zero_InLow                      (zeroN),
        .SC_MULTSEQ_decoderclearselection_OutBUS    (decClr),
        .SC_MULTSEQ_decoderloadselection_OutBUS     (decLd),
        .SC_MULTSEQ_muxselectionBUSA_OutBUS         (muxA),
        .SC_MULTSEQ_muxselectionBUSB_OutBUS         (muxB),
        .SC_MULTSEQ_aluselection_OutBUS             (alu),
        .SC_MULTSEQ_regSHIFTERclear_OutLow          (shClrN),
        .SC_MULTSEQ_regSHIFTERload_OutLow           (shLdN),
        .SC_MULTSEQ_regSHIFTERshiftselection_OutLow (shSel),
        .SC_MULTSEQ_busy_OutHigh                    (busy),
        .SC_MULTSEQ_done_OutHigh                    (done),
        .SC_MULTSEQ_error_OutHigh                   (err)
    );

    // bus muxes and ALU of the datapath
    always_comb begin
        case (muxA)
            3'd0:    busA = mcandM;
            3'd1:    busA = mplierM;
            3'd2:    busA = prodM;
            default: busA = 32'd0;
        endcase
        case (muxB)
            3'd0:    busB = mcandM;
            3'd1:    busB = mplierM;
            3'd2:    busB = prodM;
            default: busB = 32'd0;
        endcase
        case (alu)
            4'd0:    aluRes = busA;
            4'd1:    aluRes = busA + busB;
            4'd2:    aluRes = busA - 32'd1;
            default: aluRes = busA;
        endcase
        zeroN = (aluRes == 32'd0) ? 1'b0 : 1'b1;
        ovfN  = ((alu == 4'd1) && (busA[31] == busB[31]) && (aluRes[31] != busA[31])) ? 1'b0 : 1'b1;
    end

    // datapath registers
    always @(posedge clk) begin
        if (loadReq) begin
            mcandM   <= loadMcand;
            mplierM  <= loadMplier;
            addCount <= 0;
        end else begin
            if (decClr == 4'd2) prodM <= 32'd0;
            if (decLd == 4'd2) prodM <= aluRes;
            if (decLd == 4'd1) mplierM <= aluRes;
            if (!shClrN) shiftM <= 32'd0;
            else if (!shLdN) shiftM <= aluRes;
            if (alu == 4'd1) addCount <= addCount + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        chk({tag, "_decClr"}, 32'(decClr), 32'hF);
        chk({tag, "_decLd"},  32'(decLd),  32'hF);
        chk({tag, "_muxA"},   32'(muxA),   32'd0);
        chk({tag, "_muxB"},   32'(muxB),   32'd0);
        chk({tag, "_alu"},    32'(alu),    32'd0);
        chk({tag, "_shClrN"}, 32'(shClrN), 32'd1);
        chk({tag, "_shLdN"},  32'(shLdN),  32'd1);
        chk({tag, "_shSel"},  32'(shSel),  32'd0);
        chk({tag, "_busy"},   32'(busy),   32'd0);
        chk({tag, "_done"},   32'(done),   32'd0);
        chk({tag, "_error"},  32'(err),    32'd0);
    endtask

    // called at a negedge while the sequencer is idle
    task automatic loadOperands(input logic [31:0] mc, input logic [31:0] mp);
        loadMcand  = mc;
        loadMplier = mp;
        loadReq    = 1'b1;
        @(negedge clk);
        loadReq    = 1'b0;
    endtask

    // starts an operation; lat = edges from the start-sampling edge until done is seen
    task automatic runOp(input logic [31:0] mc, input logic [31:0] mp, input bit holdStart, output int l);
        loadOperands(mc, mp);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!holdStart) start = 1'b0;
        l = -1;
        for (int n = 0; n < 2000; n++) begin
            if (done) begin
                l = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rstN  = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkIdle("reset");
        rstN = 1'b1;
        @(negedge clk);

        // 9 x 3
        runOp(32'd9, 32'd3, 1'b0, lat);
        chk("t1_latency", 32'(lat), 32'd12);
        chk("t1_product", shiftM, 32'd27);
        chk("t1_error", 32'(err), 32'd0);
        chk("t1_busyInDone", 32'(busy), 32'd1);
        chk("t1_adds", 32'(addCount), 32'd3);
        chk("t1_mcandKept", mcandM, 32'd9);
        chk("t1_mplierZero", mplierM, 32'd0);
        @(negedge clk);
        chk("t1_donePulse", 32'(done), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // multiplier zero
        runOp(32'd7, 32'd0, 1'b0, lat);
        chk("t2_latency", 32'(lat), 32'd3);
        chk("t2_product", shiftM, 32'd0);
        chk("t2_adds", 32'(addCount), 32'd0);
        chk("t2_error", 32'(err), 32'd0);
        @(negedge clk);

        // overflow on the second add
        runOp(32'h7FFF_FFFF, 32'd2, 1'b0, lat);
        chk("t3_latency", 32'(lat), 32'd7);
        chk("t3_error", 32'(err), 32'd1);
        chk("t3_product", shiftM, 32'hFFFF_FFFE);
        chk("t3_prodReg", prodM, 32'hFFFF_FFFE);
        chk("t3_mplier", mplierM, 32'd1);
        chk("t3_adds", 32'(addCount), 32'd2);
        repeat (3) @(negedge clk);
        chk("t3_errorSticky", 32'(err), 32'd1);
        chk("t3_idle", 32'(busy), 32'd0);

        // 255 iterations end by zero flag, not by the limit
        runOp(32'd2, 32'd255, 1'b0, lat);
        chk("t4_latency", 32'(lat), 32'd768);
        chk("t4_product", shiftM, 32'd510);
        chk("t4_errorCleared", 32'(err), 32'd0);
        chk("t4_adds", 32'(addCount), 32'd255);
        @(negedge clk);

        // iteration limit abort
        runOp(32'd1, 32'd300, 1'b0, lat);
        chk("t5_latency", 32'(lat), 32'd768);
        chk("t5_product", shiftM, 32'd255);
        chk("t5_error", 32'(err), 32'd1);
        chk("t5_mplier", mplierM, 32'd45);
        chk("t5_adds", 32'(addCount), 32'd255);
        @(negedge clk);

        // reset in the middle of an ADD
        loadOperands(32'd5, 32'd4);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (alu == 4'd1) break;
            @(negedge clk);
        end
        chk("t6_reachedAdd", 32'(alu), 32'd1);
        rstN = 1'b0;
        @(negedge clk);
        checkIdle("t6_midReset");
        rstN = 1'b1;
        @(negedge clk);
        runOp(32'd3, 32'd4, 1'b0, lat);
        chk("t6_latency", 32'(lat), 32'd15);
        chk("t6_product", shiftM, 32'd12);
        chk("t6_error", 32'(err), 32'd0);
        chk("t6_adds", 32'(addCount), 32'd4);
        @(negedge clk);

        // start held high through busy and done
        runOp(32'd4, 32'd1, 1'b1, lat);
        chk("t7_latency", 32'(lat), 32'd6);
        chk("t7_product", shiftM, 32'd4);
        @(negedge clk);
        chk("t7_doneLow", 32'(done), 32'd0);
        chk("t7_idleGap", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t7_restart", 32'(busy), 32'd1);
        gap = -1;
        for (int n = 2; n < 50; n++) begin
            if (done) begin
                gap = n;
                break;
            end
            @(negedge clk);
        end
        chk("t7_secondDoneGap", 32'(gap), 32'd5);
        chk("t7_secondProduct", shiftM, 32'd0);
        start = 1'b0;
        @(negedge clk);
        chk("t7_secondDonePulse", 32'(done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
